cpu_core_param: RTL and testbench

- Parametrised multicycle CPU core; successor to the fixed 8-bit control/datapath pair.
- Generalises data width, address width and register count.
- Adds a variable-latency req/ack memory port, conditional branch, store-to-memory, valid/ready I/O, and fault reporting.
- Program memory is external: the host preloads it, then pulses i_start.

---
 rtl/cpu_core_pkg.sv | 43 ++++
 rtl/regfile_param.sv | 33 +++
 rtl/cpu_core_param.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_core_param.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// Shared definitions for the parametrised multicycle core: opcode values,
// controller state encoding and instruction-shape helpers.
package cpu_core_pkg;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_NOP  = 8'h01;
  localparam logic [7:0] OP_IN   = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_JMP  = 8'h04;
  localparam logic [7:0] OP_JZ   = 8'h05;
  localparam logic [7:0] OP_LDI  = 8'h06;
  localparam logic [7:0] OP_LDM  = 8'h07;
  localparam logic [7:0] OP_STM  = 8'h08;
  localparam logic [7:0] OP_ADD  = 8'h09;
  localparam logic [7:0] OP_SUB  = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_EXEC,
    S_MEM,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  // Number of operand words following the opcode word.
  function automatic logic [1:0] opnd_count(input logic [7:0] op);
    case (op)
      OP_IN, OP_OUT, OP_JMP:                          return 2'd1;
      OP_JZ, OP_LDI, OP_LDM, OP_STM, OP_ADD, OP_SUB:  return 2'd2;
      default:                                        return 2'd0;
    endcase
  endfunction

  function automatic logic op_defined(input logic [7:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/regfile_param.sv
// General register file: NUM_REGS x DATA_W, two asynchronous read ports and
// one synchronous write port, cleared by asynchronous reset.
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [RIDX_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RIDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [RIDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: clear on reset, single write per cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised multicycle CPU core with req/ack memory port, valid/ready
// input and output channels, conditional branch and fault reporting.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready
);

  localparam int RIDX_W = $clog2(NUM_REGS);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              opnd_idx;
  logic              flag_z, flag_c;
  logic              fault_q;

  logic [1:0]        n_opnd;
  logic              last_opnd;
  logic [ADDR_W-1:0] instr_len;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W:0]   sum, diff;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign n_opnd    = opnd_count(opcode);
  assign last_opnd = (({1'b0, opnd_idx} + 2'd1) == n_opnd);
  assign instr_len = ADDR_W'(n_opnd) + ADDR_W'(1);
  assign sum       = {1'b0, rd_a} + {1'b0, rd_b};
  assign diff      = {1'b0, rd_a} - {1'b0, rd_b};

  // First operand is always the register / JMP target; second is imm/address/rs.
  regfile_param #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .rd_addr_a (opnd_a[RIDX_W-1:0]),
    .rd_data_a (rd_a),
    .rd_addr_b (opnd_b[RIDX_W-1:0]),
    .rd_data_b (rd_b),
    .wr_en     (rf_we),
    .wr_addr   (opnd_a[RIDX_W-1:0]),
    .wr_data   (rf_wdata)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; memory ack is only honoured in states that request.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (i_start) state_nx = S_FETCH;
      S_FETCH:    if (i_mem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (!op_defined(opcode))  state_nx = S_FAULT;
        else if (opcode == OP_HALT) state_nx = S_HALT;
        else if (n_opnd != 2'd0)  state_nx = S_OPND;
        else                      state_nx = S_EXEC;
      end
      S_OPND: begin
        if (i_mem_ack && last_opnd) begin
          case (opcode)
            OP_IN:         state_nx = S_IN_WAIT;
            OP_OUT:        state_nx = S_OUT_WAIT;
            OP_LDM, OP_STM: state_nx = S_MEM;
            default:       state_nx = S_EXEC;
          endcase
        end
      end
      S_MEM:      if (i_mem_ack) state_nx = S_EXEC;
      S_IN_WAIT:  if (i_in_valid) state_nx = S_EXEC;
      S_OUT_WAIT: if (i_out_ready) state_nx = S_EXEC;
      S_EXEC:     state_nx = S_FETCH;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they hold through waits.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    case (state)
      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = pc;
      end
      S_OPND: begin
        o_mem_req  = 1'b1;
        o_mem_addr = pc + ADDR_W'(1) + ADDR_W'(opnd_idx);
      end
      S_MEM: begin
        o_mem_req  = 1'b1;
        o_mem_addr = opnd_b[ADDR_W-1:0];
        if (opcode == OP_STM) begin
          o_mem_we    = 1'b1;
          o_mem_wdata = rd_a;
        end
      end
      S_IN_WAIT:  o_in_ready = 1'b1;
      S_OUT_WAIT: begin
        o_out_valid = 1'b1;
        o_out_data  = rd_a;
      end
      default: ;
    endcase
  end

  assign o_busy  = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
  assign o_fault = fault_q;
  assign o_pc    = pc;

  // Register-file write selection: IN and LDM write on their handshake cycle.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state)
      S_IN_WAIT: begin
        rf_we    = i_in_valid;
        rf_wdata = i_in_data;
      end
      S_MEM: begin
        rf_we    = i_mem_ack && (opcode == OP_LDM);
        rf_wdata = i_mem_rdata;
      end
      S_EXEC: begin
        case (opcode)
          OP_LDI: begin rf_we = 1'b1; rf_wdata = opnd_b;            end
          OP_ADD: begin rf_we = 1'b1; rf_wdata = sum[DATA_W-1:0];  end
          OP_SUB: begin rf_we = 1'b1; rf_wdata = diff[DATA_W-1:0]; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Datapath registers: PC, latched instruction words, flags, sticky fault.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc       <= '0;
      opcode   <= '0;
      opnd_a   <= '0;
      opnd_b   <= '0;
      opnd_idx <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            pc      <= '0;
            fault_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            opcode   <= i_mem_rdata[7:0];
            opnd_idx <= 1'b0;
          end
        end
        S_DECODE: if (!op_defined(opcode)) fault_q <= 1'b1;
        S_OPND: begin
          if (i_mem_ack) begin
            if (!opnd_idx) opnd_a <= i_mem_rdata;
            else           opnd_b <= i_mem_rdata;
            opnd_idx <= 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD: begin
              flag_z <= (sum[DATA_W-1:0] == '0);
              flag_c <= sum[DATA_W];
            end
            OP_SUB: begin
              flag_z <= (diff[DATA_W-1:0] == '0);
              flag_c <= diff[DATA_W];
            end
            default: ;
          endcase
          if (opcode == OP_JMP)                    pc <= opnd_a[ADDR_W-1:0];
          else if (opcode == OP_JZ && rd_a == '0)  pc <= opnd_b[ADDR_W-1:0];
          else                                     pc <= pc + instr_len;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Scoreboard bench for cpu_core_param: an instruction-level interpreter
// predicts outputs, final PC, flags, fault and memory-access count.
module tb_cpu_core_param;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 8;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_fault;
  logic [AW-1:0] o_pc;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          i_in_valid;
  logic [DW-1:0] i_in_data;
  logic          o_in_ready;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          i_out_ready;

  cpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .o_busy(o_busy), .o_fault(o_fault), .o_pc(o_pc),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];   // memory seen by the DUT
  logic [7:0] mm  [256];   // model's copy
  logic [7:0] mr  [8];     // model registers
  bit         mz, mc;
  logic [7:0] exp_q [$];
  logic [7:0] in_q  [$];
  logic [7:0] min_q [$];
  logic [7:0] prog_q [$];
  int unsigned exp_txn, txn_count;
  int  mem_delay = 0;
  bit  mem_rand  = 0;
  int  out_stall = 0;
  bit  out_rand  = 0;
  int  in_hold   = 0;
  int  last_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctl"}, {26'd0, o_busy, o_fault, o_mem_req, o_mem_we, o_in_ready, o_out_valid}, 0);
    check({tag, " pc"}, o_pc, 0);
    check({tag, " mem addr/wdata"}, {o_mem_addr, o_mem_wdata}, 0);
    check({tag, " out data"}, o_out_data, 0);
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    i_start = 1'b0;
    #1;
    check_zero(tag);
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    mz = 0; mc = 0;
    exp_q.delete(); in_q.delete(); min_q.delete();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] base);
    for (int i = 0; i < prog_q.size(); i++) mem[8'(base + 8'(i))] = prog_q[i];
    prog_q.delete();
  endtask

  // Instruction-level interpreter working directly on the ISA rules.
  task automatic model_run(output logic [7:0] pc_end, output bit flt);
    logic [7:0] pc, op, a, b, x, y;
    int unsigned steps;
    bit done;
    pc = 0; done = 0; flt = 0; steps = 0; pc_end = 0;
    while (!done && steps < 2000) begin
      steps++;
      op = mm[pc]; a = mm[8'(pc + 8'd1)]; b = mm[8'(pc + 8'd2)];
      x = mr[a[2:0]]; y = mr[b[2:0]];
      exp_txn++;
      case (op)
        8'h00: begin done = 1; pc_end = pc; end
        8'h01: pc = pc + 8'd1;
        8'h02: begin exp_txn += 1; mr[a[2:0]] = min_q.pop_front(); pc = pc + 8'd2; end
        8'h03: begin exp_txn += 1; exp_q.push_back(x); pc = pc + 8'd2; end
        8'h04: begin exp_txn += 1; pc = a; end
        8'h05: begin exp_txn += 2; pc = (x == 0) ? b : pc + 8'd3; end
        8'h06: begin exp_txn += 2; mr[a[2:0]] = b; pc = pc + 8'd3; end
        8'h07: begin exp_txn += 3; mr[a[2:0]] = mm[b]; pc = pc + 8'd3; end
        8'h08: begin exp_txn += 3; mm[b] = x; pc = pc + 8'd3; end
        8'h09: begin
          exp_txn += 2;
          mc = (int'(x) + int'(y)) > 255;
          mr[a[2:0]] = 8'((int'(x) + int'(y)) % 256);
          mz = (mr[a[2:0]] == 0);
          pc = pc + 8'd3;
        end
        8'h0A: begin
          exp_txn += 2;
          mc = (x < y);
          mr[a[2:0]] = 8'((int'(x) - int'(y) + 256) % 256);
          mz = (x == y);
          pc = pc + 8'd3;
        end
        default: begin flt = 1; done = 1; pc_end = pc; end
      endcase
    end
  endtask

  task automatic run_prog(input string tag, input int bound);
    logic [7:0] pc_end;
    bit flt;
    int cyc;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    exp_txn = 0;
    txn_count = 0;
    model_run(pc_end, flt);
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    check({tag, " fault cleared on start"}, o_fault, 0);
    check({tag, " busy after start"}, o_busy, 1);
    cyc = 0; last_busy = 0;
    while (o_busy && cyc < bound) begin
      last_busy++;
      @(negedge i_clk);
      cyc++;
    end
    check({tag, " completes in bound"}, cyc < bound, 1);
    if (cyc >= bound) begin
      do_reset({tag, " recover"});
      return;
    end
    check({tag, " outputs drained"}, exp_q.size(), 0);
    check({tag, " final pc"}, o_pc, pc_end);
    check({tag, " fault"}, o_fault, flt);
    check({tag, " flags Z,C"}, {dut.flag_z, dut.flag_c}, {mz, mc});
    check({tag, " mem transactions"}, txn_count, exp_txn);
  endtask

  // Memory responder: programmable wait states, spurious acks while idle.
  initial begin
    logic [AW+DW:0] rec;
    int wait_left;
    bit in_txn;
    i_mem_ack = 0; i_mem_rdata = '0; in_txn = 0; wait_left = 0; rec = '0;
    forever begin
      @(negedge i_clk);
      i_mem_ack   = 0;
      i_mem_rdata = 8'($urandom);
      if (i_reset || !o_mem_req) begin
        in_txn    = 0;
        i_mem_ack = !i_reset && ($urandom_range(1, 0) == 1);
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          txn_count++;
          rec = {o_mem_we, o_mem_addr, o_mem_wdata};
          wait_left = mem_rand ? int'($urandom_range(mem_delay, 0)) : mem_delay;
        end else begin
          check("mem req held stable", {15'd0, o_mem_we, o_mem_addr, o_mem_wdata}, {15'd0, rec});
        end
        if (wait_left == 0) begin
          i_mem_ack = 1;
          in_txn = 0;
          if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
          else          i_mem_rdata = mem[o_mem_addr];
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Input producer.
  initial begin
    bit fire;
    fire = 0; i_in_valid = 0; i_in_data = '0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        fire = 0; i_in_valid = 0;
      end else begin
        if (fire) begin
          fire = 0;
          void'(in_q.pop_front());
          check("in ready low after transfer", o_in_ready, 0);
        end
        if (in_q.size() > 0 && in_hold == 0) begin
          i_in_valid = 1; i_in_data = in_q[0];
        end else begin
          i_in_valid = 0; i_in_data = 8'($urandom);
          if (in_hold > 0 && o_in_ready) in_hold--;
        end
        if (i_in_valid && o_in_ready) fire = 1;
      end
    end
  end

  // Output monitor: pops the scoreboard on every accepted word.
  initial begin
    bit active, done;
    int stall;
    logic [DW-1:0] held, e;
    active = 0; done = 0; stall = 0; held = '0; i_out_ready = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        active = 0; done = 0; i_out_ready = 0;
      end else begin
        if (done) begin
          done = 0; active = 0;
          check("out valid drops after transfer", o_out_valid, 0);
        end
        i_out_ready = 0;
        if (o_out_valid) begin
          if (!active) begin
            active = 1; held = o_out_data;
            stall = out_rand ? int'($urandom_range(3, 0)) : out_stall;
          end else begin
            check("out data held stable", o_out_data, held);
          end
          if (stall == 0) begin
            i_out_ready = 1; done = 1;
            if (exp_q.size() == 0) check("unexpected out word", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("out data", o_out_data, e);
            end
          end else begin
            stall--;
          end
        end
      end
    end
  end

  initial begin
    int cyc, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) % 256);
    do_reset("reset");

    // LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT
    prog_q = '{8'h06, 8'h01, 8'h05, 8'h06, 8'h02, 8'h03, 8'h09, 8'h01, 8'h02,
               8'h03, 8'h01, 8'h00};
    load_prog(8'h00);
    run_prog("add", 200);

    // Wrapping ADD then JZ to 0x20, OUT r0, HALT; zero-wait then 3 waits
    prog_q = '{8'h06, 8'h00, 8'hFF, 8'h06, 8'h01, 8'h01, 8'h09, 8'h00, 8'h01,
               8'h05, 8'h00, 8'h20};
    load_prog(8'h00);
    prog_q = '{8'h03, 8'h00, 8'h00};
    load_prog(8'h20);
    run_prog("jz wait0", 200);
    mem_delay = 3;
    run_prog("jz wait3", 600);
    mem_delay = 0;

    // JZ not taken
    prog_q = '{8'h06, 8'h02, 8'h01, 8'h05, 8'h02, 8'h30, 8'h00};
    load_prog(8'h00);
    run_prog("jz not taken", 200);

    // IN r3 (valid withheld) ; STM ; LDM ; OUT r4 with consumer stall
    prog_q = '{8'h02, 8'h03, 8'h08, 8'h03, 8'h40, 8'h07, 8'h04, 8'h40,
               8'h03, 8'h04, 8'h00};
    load_prog(8'h00);
    in_q.push_back(8'h5A); min_q.push_back(8'h5A);
    in_hold = 5; out_stall = 4;
    run_prog("in/stm/ldm/out", 300);
    out_stall = 0;

    // NOP latency
    prog_q = '{8'h01, 8'h01, 8'h00};
    load_prog(8'h00);
    run_prog("nop", 100);
    check("nop nop halt busy cycles", last_busy, 8);

    // Undefined opcode at address 2, then read registers back
    prog_q = '{8'h01, 8'h01, 8'h7E};
    load_prog(8'h00);
    run_prog("fault", 100);
    prog_q = '{8'h03, 8'h01, 8'h03, 8'h04, 8'h03, 8'h00, 8'h00};
    load_prog(8'h00);
    run_prog("regs after fault", 200);

    // PC wraps while fetching operands; lands on undefined 0xFE at address 1
    prog_q = '{8'h04, 8'hFE};
    load_prog(8'h00);
    prog_q = '{8'h06, 8'h07};
    load_prog(8'hFE);
    run_prog("pc wrap", 200);

    // Randomised programs with random wait states and consumer stalls
    mem_delay = 3; mem_rand = 1; out_rand = 1;
    for (int t = 0; t < 20; t++) begin
      n = int'($urandom_range(12, 4));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(6, 0))
          0: prog_q = {prog_q, 8'h06, 8'($urandom), 8'($urandom)};
          1: prog_q = {prog_q, 8'h09, 8'($urandom), 8'($urandom)};
          2: prog_q = {prog_q, 8'h0A, 8'($urandom), 8'($urandom)};
          3: prog_q = {prog_q, 8'h03, 8'($urandom)};
          4: prog_q = {prog_q, 8'h01};
          5: prog_q = {prog_q, 8'h08, 8'($urandom), 8'(8'hC0 | 8'($urandom_range(63, 0)))};
          default: prog_q = {prog_q, 8'h07, 8'($urandom), 8'(8'hC0 | 8'($urandom_range(63, 0)))};
        endcase
      end
      prog_q.push_back(8'h00);
      load_prog(8'h00);
      run_prog("random", 3000);
    end
    mem_rand = 0; out_rand = 0;

    // Asynchronous reset in the middle of an LDM data access
    prog_q = '{8'h07, 8'h02, 8'h40, 8'h00};
    load_prog(8'h00);
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    cyc = 0;
    while (!(o_mem_req && o_mem_addr == 8'h40) && cyc < 50) begin
      @(negedge i_clk);
      cyc++;
    end
    check("ldm access reached", cyc < 50, 1);
    #2;
    do_reset("mid-ldm reset");
    mem_delay = 0;

    // Registers cleared by reset
    prog_q = '{8'h03, 8'h02, 8'h03, 8'h01, 8'h00};
    load_prog(8'h00);
    run_prog("regs after reset", 200);

    repeat (3) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
